// File: rtl/hilo_div_if.sv
// hilo_div_if: request/response bundle between the execute stage and the
// iterative divider.
//   start      : request a divide (sampled only while the divider is idle)
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   a, b       : dividend (rs) and divisor (rt)
//   cancel     : exception/flush, aborts any operation
//   busy       : divider is iterating
//   ready      : one-cycle pulse, result is valid
//   result     : {remainder (HI), quotient (LO)}
// The master modport is the pipeline side; the slave modport is the divider.
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cancel;
  logic                 busy;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, a, b, cancel,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output busy, ready, result
  );
endinterface

// File: rtl/hilo_div.sv
// hilo_div: radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per
// clock. Produces the {HI,LO} = {remainder, quotient} value for the hilo
// register.
//   clk    : system clock, rising edge
//   resetn : asynchronous, active-low reset
//   bus    : hilo_div_if slave (start/signed_div/a/b/cancel in,
//            busy/ready/result out)
// Latency: start accepted at edge E0 gives ready in the cycle after E0+WIDTH,
// or in the cycle after E0 when the divisor is zero (result forced to 0).
module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  hilo_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [2*WIDTH-1:0]   work_reg, work_next;    // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0]     div_reg, div_next;      // divisor magnitude
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;

  // Operand magnitudes; in unsigned mode the operands pass through untouched.
  // Negating 0x80000000 yields 0x80000000, which is the correct magnitude
  // when read as unsigned.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (bus.signed_div && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
  assign mag_b = (bus.signed_div && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;

  // One iteration: shift {rem,quot} left by one. The shifted remainder can be
  // one bit wider than WIDTH, so the trial subtract keeps that carry bit plus
  // a borrow bit to decide whether the divisor fits.
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH+1:0]     diff;
  logic                 take;
  logic [2*WIDTH-1:0]   work_iter;

  assign rem_shift = work_reg[2*WIDTH-1:WIDTH-1];
  assign diff      = {1'b0, rem_shift} - {2'b00, div_reg};
  assign take      = ~diff[WIDTH+1];
  assign work_iter = take ? {diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1}
                          : {work_reg[2*WIDTH-2:0], 1'b0};

  // Sign correction applied to the final iteration's output: quotient sign is
  // a^b, remainder sign follows the dividend.
  logic [WIDTH-1:0] q_raw, r_raw, q_fix, r_fix;
  assign q_raw = work_iter[WIDTH-1:0];
  assign r_raw = work_iter[2*WIDTH-1:WIDTH];
  assign q_fix = neg_q_reg ? ({WIDTH{1'b0}} - q_raw) : q_raw;
  assign r_fix = neg_r_reg ? ({WIDTH{1'b0}} - r_raw) : r_raw;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      work_reg   <= '0;
      div_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      work_reg   <= work_next;
      div_reg    <= div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    work_next   = work_reg;
    div_next    = div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          div_next   = mag_b;
          work_next  = {{WIDTH{1'b0}}, mag_a};
          neg_q_next = bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_r_next = bus.signed_div && bus.a[WIDTH-1];
          count_next = '0;
          if (bus.b == '0) begin
            // Divide by zero has a defined all-zero result and skips iterating.
            state_next  = DONE;
            result_next = '0;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        work_next  = work_iter;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next  = DONE;
          result_next = {r_fix, q_fix};
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A flush wins over everything and must not disturb the visible result.
    if (bus.cancel) begin
      state_next  = IDLE;
      result_next = result_reg;
    end
  end

  assign bus.busy   = (state_reg == BUSY);
  assign bus.ready  = (state_reg == DONE) && !bus.cancel;
  assign bus.result = result_reg;

endmodule
